// File: rtl/posit_data_extract_pipe.sv
// rtl/posit_data_extract_pipe.sv - two-stage pipelined posit field extractor
//
// Splits a Posit<POSIT_WIDTH,POSIT_ES> word into sign, NaR, zero, signed
// scale ((k << ES) + exp) and an MSB-aligned fraction without the hidden bit.
// Stage 1 registers sign/specials and the absolute value; stage 2 registers
// the decoded regime/exponent/fraction. Both stages use rts/rtr handshakes.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rts_i, rtr_o      upstream valid / ready
//   posit_word_i      posit operand
//   rts_o, rtr_i      downstream valid / ready
//   sign, inf, zero   sign bit, NaR flag, zero flag
//   scale             signed (k << ES) + exp
//   fraction          fraction bits, MSB-aligned, zero-padded
//   tag_i, tag_o      sideband tag, present only with POSIT_EXTRACT_TAG_EN
//
// Optional feature macro: POSIT_EXTRACT_TAG_EN

module posit_data_extract_pipe #(
    parameter int  POSIT_WIDTH = 16,
    parameter int  POSIT_ES    = 1,
    parameter int  TAG_WIDTH   = 8,
    localparam int SCALE_WIDTH = $clog2((POSIT_WIDTH - 1) << POSIT_ES) + 1,
    localparam int FRAC_WIDTH  = POSIT_WIDTH - POSIT_ES - 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rts_i,
    output logic                          rtr_o,
    input  logic [POSIT_WIDTH-1:0]        posit_word_i,
    output logic                          rts_o,
    input  logic                          rtr_i,
    output logic                          sign,
    output logic                          inf,
    output logic                          zero,
    output logic signed [SCALE_WIDTH-1:0] scale,
    output logic [FRAC_WIDTH-1:0]         fraction
`ifdef POSIT_EXTRACT_TAG_EN
    ,
    input  logic [TAG_WIDTH-1:0]          tag_i,
    output logic [TAG_WIDTH-1:0]          tag_o
`endif
);

    localparam int N  = POSIT_WIDTH;
    localparam int SW = SCALE_WIDTH;
    localparam int BW = N - 1;           // word without the sign bit
    localparam int RW = N - 3;           // bits that can follow a minimal regime
    localparam int CW = $clog2(N) + 1;   // regime run-length counter width

    if (POSIT_WIDTH < 8 || POSIT_WIDTH > 32) begin : g_bad_width
        $error("POSIT_WIDTH must be in 8..32");
    end
    if (POSIT_ES < 0 || POSIT_ES > 4) begin : g_bad_es
        $error("POSIT_ES must be in 0..4");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
        $error("TAG_WIDTH must be at least 1");
    end

    // Stage 1 state
    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_q,  s1_sign_d;
    logic          s1_inf_q,   s1_inf_d;
    logic          s1_zero_q,  s1_zero_d;
    logic [BW-1:0] s1_body_q,  s1_body_d;

    // Stage 2 state
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q,  s2_sign_d;
    logic                  s2_inf_q,   s2_inf_d;
    logic                  s2_zero_q,  s2_zero_d;
    logic [SW-1:0]         s2_scale_q, s2_scale_d;
    logic [FRAC_WIDTH-1:0] s2_frac_q,  s2_frac_d;

`ifdef POSIT_EXTRACT_TAG_EN
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
`endif

    // Handshake
    logic adv1;
    logic s1_load;
    logic s2_load;

    always_comb begin
        adv1    = !s2_valid_q || rtr_i;
        rtr_o   = !rst && (!s1_valid_q || adv1);
        s1_load = rts_i && rtr_o;
        s2_load = s1_valid_q && adv1;
    end

    // Stage 1: sign, specials and absolute value (low N-1 bits of |word|)
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_inf_d   = s1_inf_q;
        s1_zero_d  = s1_zero_q;
        s1_body_d  = s1_body_q;
`ifdef POSIT_EXTRACT_TAG_EN
        s1_tag_d   = s1_tag_q;
`endif
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = posit_word_i[N-1];
            s1_inf_d   = posit_word_i[N-1] && ~|posit_word_i[N-2:0];
            s1_zero_d  = !posit_word_i[N-1] && ~|posit_word_i[N-2:0];
            // Two's complement of the low bits equals the low bits of -word.
            s1_body_d  = posit_word_i[N-1] ? (~posit_word_i[N-2:0] + BW'(1))
                                           : posit_word_i[N-2:0];
`ifdef POSIT_EXTRACT_TAG_EN
            s1_tag_d   = tag_i;
`endif
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Regime decode from the stage 1 registers
    logic          r0;
    logic          run;
    logic [CW-1:0] run_len;
    logic [RW-1:0] rem;
    logic [SW-1:0] m_ext;
    logic [SW-1:0] k_val;
    logic [SW-1:0] exp_ext;

    always_comb begin
        r0      = s1_body_q[BW-1];
        run     = 1'b1;
        run_len = '0;
        for (int i = BW - 1; i >= 0; i--) begin
            if (run && (s1_body_q[i] == r0)) begin
                run_len = run_len + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
        // The regime plus terminator always consumes at least the top two
        // bits, so shifting the low N-3 bits by (m-1) left-aligns the
        // remainder. An unterminated regime shifts everything out.
        rem   = s1_body_q[RW-1:0] << (run_len - CW'(1));
        m_ext = SW'(run_len);
        k_val = r0 ? (m_ext - SW'(1)) : (SW'(0) - m_ext);
    end

    if (POSIT_ES > 0) begin : g_exp
        assign exp_ext = SW'(rem[RW-1 -: POSIT_ES]);
    end else begin : g_no_exp
        assign exp_ext = '0;
    end

    // Stage 2: decoded fields
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_inf_d   = s2_inf_q;
        s2_zero_d  = s2_zero_q;
        s2_scale_d = s2_scale_q;
        s2_frac_d  = s2_frac_q;
`ifdef POSIT_EXTRACT_TAG_EN
        s2_tag_d   = s2_tag_q;
`endif
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_sign_d  = s1_sign_q;
            s2_inf_d   = s1_inf_q;
            s2_zero_d  = s1_zero_q;
            if (s1_inf_q || s1_zero_q) begin
                s2_scale_d = '0;
                s2_frac_d  = '0;
            end else begin
                s2_scale_d = (k_val << POSIT_ES) + exp_ext;
                s2_frac_d  = rem[FRAC_WIDTH-1:0];
            end
`ifdef POSIT_EXTRACT_TAG_EN
            s2_tag_d   = s1_tag_q;
`endif
        end else if (rtr_i) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_body_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_scale_q <= '0;
            s2_frac_q  <= '0;
`ifdef POSIT_EXTRACT_TAG_EN
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
            s1_body_q  <= s1_body_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_inf_q   <= s2_inf_d;
            s2_zero_q  <= s2_zero_d;
            s2_scale_q <= s2_scale_d;
            s2_frac_q  <= s2_frac_d;
`ifdef POSIT_EXTRACT_TAG_EN
            s1_tag_q   <= s1_tag_d;
            s2_tag_q   <= s2_tag_d;
`endif
        end
    end

    assign rts_o    = s2_valid_q;
    assign sign     = s2_sign_q;
    assign inf      = s2_inf_q;
    assign zero     = s2_zero_q;
    assign scale    = s2_scale_q;
    assign fraction = s2_frac_q;
`ifdef POSIT_EXTRACT_TAG_EN
    assign tag_o    = s2_tag_q;
`endif

endmodule

// File: tb/tb_posit_data_extract_pipe.sv
// tb/tb_posit_data_extract_pipe.sv - self-checking bench for posit_data_extract_pipe

module tb_posit_data_extract_pipe;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int FW = N - ES - 3;
    localparam int SW = $clog2((N - 1) << ES) + 1;
    localparam int TW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rts_i;
    logic                 rtr_o;
    logic [N-1:0]         posit_word_i;
    logic                 rts_o;
    logic                 rtr_i;
    logic                 sign;
    logic                 inf;
    logic                 zero;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        fraction;
    logic [TW-1:0]        tag_v;
`ifdef POSIT_EXTRACT_TAG_EN
    logic [TW-1:0]        tag_o;
`endif

    always #5 clk = ~clk;

    posit_data_extract_pipe #(
        .POSIT_WIDTH(N),
        .POSIT_ES   (ES),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rts_i       (rts_i),
        .rtr_o       (rtr_o),
        .posit_word_i(posit_word_i),
        .rts_o       (rts_o),
        .rtr_i       (rtr_i),
        .sign        (sign),
        .inf         (inf),
        .zero        (zero),
        .scale       (scale),
        .fraction    (fraction)
`ifdef POSIT_EXTRACT_TAG_EN
        ,
        .tag_i       (tag_v),
        .tag_o       (tag_o)
`endif
    );

    typedef struct {
        logic          s;
        logic          nar;
        logic          z;
        int            sc;
        int            fr;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bitat(input int a, input int pos);
        return (pos < 0) ? 0 : ((a >> pos) & 1);
    endfunction

    // Reads the posit as a bit stream: regime run, terminator, ES exponent
    // bits, then fraction bits; reads past the end of the word give 0.
    function automatic exp_t model(input logic [N-1:0] w, input logic [TW-1:0] t);
        exp_t e;
        int a, pos, m, k, ev, fv, r0;
        e.tag = t;
        e.s   = w[N-1];
        e.nar = 1'b0;
        e.z   = 1'b0;
        e.sc  = 0;
        e.fr  = 0;
        a = int'(w);
        if ((a % (1 << (N - 1))) == 0) begin
            if (w[N-1]) e.nar = 1'b1;
            else        e.z   = 1'b1;
            return e;
        end
        if (w[N-1]) a = (1 << N) - a;
        pos = N - 2;
        r0  = bitat(a, pos);
        m   = 0;
        while (pos >= 0 && bitat(a, pos) == r0) begin
            m++;
            pos--;
        end
        k = (r0 == 1) ? m - 1 : -m;
        pos--;
        ev = 0;
        repeat (ES) begin
            ev = ev * 2 + bitat(a, pos);
            pos--;
        end
        fv = 0;
        repeat (FW) begin
            fv = fv * 2 + bitat(a, pos);
            pos--;
        end
        e.sc = k * (1 << ES) + ev;
        e.fr = fv;
        return e;
    endfunction

    // One clock: handshakes are evaluated at the falling edge, inputs change
    // 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        int   sx;
        @(negedge clk);
        last_acc = rts_i && rtr_o;
        if (rts_o && rtr_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {31'd0, rts_o}, 32'd0);
            end else begin
                e  = sb.pop_front();
                sx = scale;
                chk("sb_sign", {31'd0, sign}, {31'd0, e.s});
                chk("sb_inf", {31'd0, inf}, {31'd0, e.nar});
                chk("sb_zero", {31'd0, zero}, {31'd0, e.z});
                chk("sb_scale", sx, e.sc);
                chk("sb_frac", {{(32-FW){1'b0}}, fraction}, e.fr);
`ifdef POSIT_EXTRACT_TAG_EN
                chk("sb_tag", {{(32-TW){1'b0}}, tag_o}, {{(32-TW){1'b0}}, e.tag});
`endif
            end
        end
        if (rts_i && rtr_o) sb.push_back(model(posit_word_i, tag_v));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic s, input logic nar, input logic z,
                           input int sc, input int fr);
        int sx;
        sx = scale;
        chk({nm, "_sign"}, {31'd0, sign}, {31'd0, s});
        chk({nm, "_inf"}, {31'd0, inf}, {31'd0, nar});
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, z});
        chk({nm, "_scale"}, sx, sc);
        chk({nm, "_frac"}, {{(32-FW){1'b0}}, fraction}, fr);
    endtask

    task automatic single(input string nm, input logic [N-1:0] w, input logic s, input logic nar,
                          input logic z, input int sc, input int fr);
        rtr_i = 1'b1;
        rts_i = 1'b1;
        posit_word_i = w;
        tick();
        rts_i = 1'b0;
        posit_word_i = '0;
        tick();
        chk({nm, "_rts"}, {31'd0, rts_o}, 32'd1);
        chk_out(nm, s, nar, z, sc, fr);
        tick();
    endtask

    logic [N-1:0] tp_w[3];
    int           tp_sc[3];
    int           tp_fr[3];

    initial begin
        tp_w  = '{16'h4000, 16'h5000, 16'h4800};
        tp_sc = '{0, 1, 0};
        tp_fr = '{0, 0, 'h800};

        rst = 1'b1;
        rts_i = 1'b0;
        rtr_i = 1'b0;
        posit_word_i = '0;
        tag_v = '0;
        last_acc = 1'b0;
        tick();
        tick();
        chk("rst_rts", {31'd0, rts_o}, 32'd0);
        chk("rst_rtr", {31'd0, rtr_o}, 32'd0);
        chk_out("rst", 1'b0, 1'b0, 1'b0, 0, 0);
        rst = 1'b0;
        #1;
        chk("rel_rtr", {31'd0, rtr_o}, 32'd1);

        // Three back-to-back words with downstream always ready
        rtr_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            rts_i = (c < 3);
            posit_word_i = (c < 3) ? tp_w[c] : '0;
            chk("tp_rts", {31'd0, rts_o}, {31'd0, (c >= 2 && c <= 4)});
            if (c >= 2 && c <= 4) chk_out("tp", 1'b0, 1'b0, 1'b0, tp_sc[c-2], tp_fr[c-2]);
            tick();
        end

        // Extremes, truncated exponent and specials
        single("max", 16'h7FFF, 1'b0, 1'b0, 1'b0, 28, 0);
        single("min", 16'h0001, 1'b0, 1'b0, 1'b0, -28, 0);
        single("neg1", 16'hC000, 1'b1, 1'b0, 1'b0, 0, 0);
        single("trunc_exp", 16'h7FFE, 1'b0, 1'b0, 1'b0, 26, 0);
        single("last_exp", 16'h7FFD, 1'b0, 1'b0, 1'b0, 25, 0);
        single("nar", 16'h8000, 1'b1, 1'b1, 1'b0, 0, 0);
        single("zero", 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0);

        // Backpressure: two words fill the pipe, the third waits
        rtr_i = 1'b0;
        rts_i = 1'b1;
        posit_word_i = 16'h4800;
        tick();
        posit_word_i = 16'h5000;
        tick();
        posit_word_i = 16'h7FFF;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rtr", {31'd0, rtr_o}, 32'd0);
            chk("bp_rts", {31'd0, rts_o}, 32'd1);
            chk_out("bp_hold", 1'b0, 1'b0, 1'b0, 0, 'h800);
            tick();
        end
        rtr_i = 1'b1;
        tick();
        rts_i = 1'b0;
        posit_word_i = '0;
        chk_out("bp_second", 1'b0, 1'b0, 1'b0, 1, 0);
        tick();
        chk("bp_third_rts", {31'd0, rts_o}, 32'd1);
        chk_out("bp_third", 1'b0, 1'b0, 1'b0, 28, 0);
        tick();
        chk("bp_empty_rts", {31'd0, rts_o}, 32'd0);

        // Reset with two words in flight
        rtr_i = 1'b0;
        rts_i = 1'b1;
        posit_word_i = 16'h5000;
        tick();
        posit_word_i = 16'h4800;
        tick();
        rts_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_rts", {31'd0, rts_o}, 32'd0);
        chk("mid_rst_rtr", {31'd0, rtr_o}, 32'd0);
        chk_out("mid_rst", 1'b0, 1'b0, 1'b0, 0, 0);
        sb.delete();
        rst = 1'b0;
        #1;
        chk("mid_rel_rtr", {31'd0, rtr_o}, 32'd1);
        single("post_rst", 16'h4000, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef POSIT_EXTRACT_TAG_EN
        // Tagged words under random downstream readiness
        for (int t = 0; t < 3; t++) begin
            int budget;
            budget = 0;
            rts_i = 1'b1;
            posit_word_i = N'($urandom);
            tag_v = TW'(8'h11 * (t + 1));
            do begin
                rtr_i = 1'($urandom_range(0, 1));
                tick();
                budget++;
            end while (!last_acc && budget < 20);
            chk("tag_accept", {31'd0, last_acc}, 32'd1);
        end
        rts_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rtr_i = 1'($urandom_range(0, 1));
            tick();
        end
        rtr_i = 1'b1;
        repeat (3) tick();
        chk("tag_drained", sb.size(), 32'd0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            rts_i = 1'($urandom_range(0, 1));
            rtr_i = ($urandom_range(0, 3) != 0);
            tag_v = TW'($urandom);
            case (sel)
                0:       posit_word_i = 16'h0000;
                1:       posit_word_i = 16'h8000;
                2:       posit_word_i = {1'($urandom), {(N-2){1'b1}}, 1'($urandom)};
                3:       posit_word_i = {1'($urandom), {(N-2){1'b0}}, 1'b1};
                default: posit_word_i = N'($urandom);
            endcase
            tick();
        end
        rts_i = 1'b0;
        rtr_i = 1'b1;
        repeat (4) tick();
        chk("final_drained", sb.size(), 32'd0);
        chk("final_rts", {31'd0, rts_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
